// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Purpose  : Shared slot state encoding and sizing helper for the scoreboard.
// Revision : 1.0
// ============================================================================
package sb_pkg;

   typedef enum logic [0:0] {
      SLOT_FREE  = 1'b0,
      SLOT_TRACK = 1'b1
   } slot_state_e;

   // Index width that never collapses to zero bits for a single slot
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sb_slot_tracker
// Purpose  : One tracked-packet slot: captured data plus distance to FIFO head.
// Revision : 1.0
// ============================================================================
module sb_slot_tracker
   import sb_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int CNTWID = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              pop_eff,
   input  logic [WIDTH-1:0]  cap_data,
   input  logic [CNTWID-1:0] cap_pos,
   output logic              tracking,
   output logic              exiting,
   output logic [WIDTH-1:0]  data
);

   slot_state_e       r_state;
   logic [CNTWID-1:0] r_pos;
   logic [WIDTH-1:0]  r_data;

   assign tracking = (r_state == SLOT_TRACK);
   // Suppressed during reset so a discarded slot never reports an exit
   assign exiting  = tracking & pop_eff & (r_pos == CNTWID'(1)) & ~rst;
   assign data     = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SLOT_FREE;
         r_pos   <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            SLOT_FREE: begin
               if (capture) begin
                  r_state <= SLOT_TRACK;
                  r_data  <= cap_data;
                  r_pos   <= cap_pos;
               end
            end
            SLOT_TRACK: begin
               if (pop_eff) begin
                  if (r_pos == CNTWID'(1)) r_state <= SLOT_FREE;
                  else                     r_pos   <= r_pos - CNTWID'(1);
               end
            end
            default: r_state <= SLOT_FREE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/multi_packet_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : multi_packet_scoreboard
// Purpose  : FIFO-order scoreboard tracking up to NUM_TRACK packets; optional
//            sticky failure latch enabled by macro SB_STICKY_FAIL_EN.
// Revision : 1.0
// ============================================================================
module multi_packet_scoreboard
   import sb_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int NUM_TRACK = 2,
   parameter int CNTWID    = $clog2(DEPTH) + 1,
   parameter int SLOTW     = clog2_min1(NUM_TRACK)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 start,
   input  logic [WIDTH-1:0]     data_in,
   input  logic [WIDTH-1:0]     data_out,
   output logic                 empty,
   output logic                 full,
   output logic [CNTWID-1:0]    occ,
   output logic [NUM_TRACK-1:0] tracking,
   output logic                 chk_vld,
   output logic [SLOTW-1:0]     chk_slot,
   output logic [WIDTH-1:0]     chk_expected,
   output logic                 ovf,
   output logic                 udf,
   output logic                 fail,
   output logic                 prop_signal
);

   logic [CNTWID-1:0]    r_occ;
   logic                 w_push_eff;
   logic                 w_pop_eff;
   logic [CNTWID-1:0]    w_cap_pos;
   logic [NUM_TRACK-1:0] w_capture;
   logic [NUM_TRACK-1:0] w_exiting;
   logic [WIDTH-1:0]     w_slot_data [NUM_TRACK];
   logic                 w_found;
   logic                 w_ok;

   assign occ        = r_occ;
   assign empty      = (r_occ == '0);
   assign full       = (r_occ == CNTWID'(DEPTH));
   assign w_push_eff = push & ~full;
   assign w_pop_eff  = pop & ~empty;
   assign ovf        = push & full;
   assign udf        = pop & empty;
   // Position after this cycle's pop, counted from the head (1 = head)
   assign w_cap_pos  = r_occ - CNTWID'(w_pop_eff) + CNTWID'(1);

   always_ff @(posedge clk) begin
      if (rst) r_occ <= '0;
      else     r_occ <= r_occ + CNTWID'(w_push_eff) - CNTWID'(w_pop_eff);
   end

   // Lowest-index FREE slot wins; a slot exiting this cycle is still TRACK here
   always_comb begin
      w_capture = '0;
      w_found   = 1'b0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         if (!tracking[i] && !w_found) begin
            w_capture[i] = start & w_push_eff;
            w_found      = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TRACK; gi++) begin : g_slot
         sb_slot_tracker #(
            .WIDTH  (WIDTH),
            .CNTWID (CNTWID)
         ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .capture  (w_capture[gi]),
            .pop_eff  (w_pop_eff),
            .cap_data (data_in),
            .cap_pos  (w_cap_pos),
            .tracking (tracking[gi]),
            .exiting  (w_exiting[gi]),
            .data     (w_slot_data[gi])
         );
      end
   endgenerate

   always_comb begin
      chk_vld      = |w_exiting;
      chk_slot     = '0;
      chk_expected = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         if (w_exiting[i]) begin
            chk_slot     = SLOTW'(i);
            chk_expected = w_slot_data[i];
         end
      end
   end

   assign w_ok = ~chk_vld | (data_out == chk_expected);

`ifdef SB_STICKY_FAIL_EN
   logic r_fail;

   always_ff @(posedge clk) begin
      if (rst)        r_fail <= 1'b0;
      else if (!w_ok) r_fail <= 1'b1;
   end

   assign fail        = r_fail;
   assign prop_signal = w_ok & ~r_fail;
`else
   assign fail        = 1'b0;
   assign prop_signal = w_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_packet_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_packet_scoreboard
// Purpose  : Directed bench with a queue-based reference FIFO model.
// Revision : 1.0
// ============================================================================
module tb_multi_packet_scoreboard;

   logic       clk = 1'b0;
   logic       rst, push, pop, start;
   logic [7:0] data_in, data_out;
   logic       empty, full, chk_vld, ovf, udf, fail, prop_signal;
   logic [3:0] occ;
   logic [1:0] tracking;
   logic [0:0] chk_slot;
   logic [7:0] chk_expected;

   multi_packet_scoreboard #(.DEPTH(8), .WIDTH(8), .NUM_TRACK(2)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .start(start),
      .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
      .occ(occ), .tracking(tracking), .chk_vld(chk_vld), .chk_slot(chk_slot),
      .chk_expected(chk_expected), .ovf(ovf), .udf(udf), .fail(fail),
      .prop_signal(prop_signal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         trk;
      int         slot;
   } ent_t;

   ent_t     q[$];
   bit [1:0] m_trk;
   bit       m_fail;
   int       n_pass;
   int       n_fail;
   int       n_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic post_checks();
      chk("occ", 32'(occ), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 8));
      chk("tracking", 32'(tracking), 32'(m_trk));
      chk("fail", 32'(fail), 32'(m_fail));
   endtask

   task automatic step(input bit p, input bit o, input bit s, input logic [7:0] din, input bit bad);
      bit m_full, m_empty, pe, oe, ev, ok, exp_prop;
      int es, k;
      logic [7:0] ed, dout;
      @(negedge clk);
      m_full  = (q.size() == 8);
      m_empty = (q.size() == 0);
      pe = p && !m_full;
      oe = o && !m_empty;
      ev = 1'b0; es = 0; ed = 8'h00;
      if (oe && q[0].trk) begin
         ev = 1'b1; es = q[0].slot; ed = q[0].d;
      end
      dout = m_empty ? 8'h00 : (q[0].d ^ (bad ? 8'h07 : 8'h00));
      push = p; pop = o; start = s; data_in = din; data_out = dout;
      ok = !ev || (dout == ed);
`ifdef SB_STICKY_FAIL_EN
      exp_prop = ok && !m_fail;
`else
      exp_prop = ok;
`endif
      #4;
      chk("ovf", 32'(ovf), 32'(p && m_full));
      chk("udf", 32'(udf), 32'(o && m_empty));
      chk("chk_vld", 32'(chk_vld), 32'(ev));
      chk("chk_slot", 32'(chk_slot), 32'(es));
      chk("chk_expected", 32'(chk_expected), 32'(ed));
      chk("prop_signal", 32'(prop_signal), 32'(exp_prop));
      k = -1;
      if (s && pe)
         for (int i = 0; i < 2; i++)
            if (!m_trk[i] && k < 0) k = i;
      @(posedge clk);
      if (oe) begin
         if (q[0].trk) m_trk[q[0].slot] = 1'b0;
         void'(q.pop_front());
      end
      if (pe) begin
         q.push_back('{din, (k >= 0), k});
         if (k >= 0) m_trk[k] = 1'b1;
      end
`ifdef SB_STICKY_FAIL_EN
      if (!ok) m_fail = 1'b1;
`endif
      #1;
      post_checks();
   endtask

   task automatic do_reset(input bit o);
      @(negedge clk);
      rst = 1'b1; push = 1'b0; pop = o; start = 1'b0; data_out = 8'h00;
      #4;
      chk("rst_chk_vld", 32'(chk_vld), 32'd0);
      @(posedge clk);
      q.delete();
      m_trk  = 2'b00;
      m_fail = 1'b0;
      #1;
      post_checks();
      @(negedge clk);
      rst = 1'b0; pop = 1'b0;
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      m_trk = 2'b00; m_fail = 1'b0;
      rst = 1'b1; push = 1'b0; pop = 1'b0; start = 1'b0;
      data_in = 8'h00; data_out = 8'h00;
      do_reset(1'b0);
      chk("reset_prop", 32'(prop_signal), 32'd1);

      // Single tracked packet at the head
      step(1, 0, 1, 8'hA5, 0);
      step(1, 0, 0, 8'hB1, 0);
      step(1, 0, 0, 8'hB2, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);

      // Two tracked packets, the second one mismatches
      step(1, 0, 1, 8'h11, 0);
      step(1, 0, 0, 8'h22, 0);
      step(1, 0, 1, 8'h33, 0);
      step(0, 1, 0, 8'h00, 0);
      step(0, 1, 0, 8'h00, 0);
      step(0, 1, 0, 8'h00, 1);

      // Fill with both slots busy, overflow, slot reuse, drain and underflow
      for (int i = 0; i < 8; i++) step(1, 0, (i < 3), 8'(8'h40 + i), 0);
      step(1, 0, 1, 8'hEE, 0);
      step(0, 1, 0, 8'h00, 0);
      step(1, 0, 1, 8'h5C, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, 0);
      step(0, 1, 0, 8'h00, 0);
      step(1, 1, 0, 8'h66, 0);
      step(0, 1, 0, 8'h00, 0);

      // Capture with simultaneous pop at occupancy 3
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h70 + i), 0);
      step(1, 1, 1, 8'h77, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);

      // Reset while tracking with a head exit pending
      step(1, 0, 1, 8'hC1, 0);
      step(1, 0, 1, 8'hC2, 0);
      do_reset(1'b1);
      step(1, 0, 1, 8'hD0, 0);
      step(0, 1, 0, 8'h00, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
